// File: rtl/uart_tx_scheduler_if.sv
// Request/grant and transmitter-side signals between the requesters, the
// scheduler and the UART transmitter.
interface uart_tx_scheduler_if;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       xmt_empty;
  logic       shift_ld, clk_enb;
  logic [7:0] data_out;
  logic       gnt0, gnt1;
  logic       done, done_id;
  logic       busy;
  logic [7:0] frame_cnt;

  modport slave (
    input  req0, req1, data0, data1, xmt_empty,
    output shift_ld, clk_enb, data_out, gnt0, gnt1, done, done_id, busy, frame_cnt
  );

  modport master (
    output req0, req1, data0, data1, xmt_empty,
    input  shift_ld, clk_enb, data_out, gnt0, gnt1, done, done_id, busy, frame_cnt
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding one UART transmitter from two requesters;
// drives the transmitter's bit-rate enable, load/shift control and payload.
module uart_tx_scheduler (
  input  logic                  clock,
  input  logic                  reset,
  uart_tx_scheduler_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t     r_state, w_next;
  logic [3:0] r_div;
  logic       r_last;
  logic [7:0] r_data, r_fcnt;
  logic       r_gnt0, r_gnt1, r_done, r_done_id;
  logic       w_clk_enb, w_winner, w_accept, w_finish;

  assign w_clk_enb = (r_div == 4'd7);
  // On a tie the requester that did not win last time goes first.
  assign w_winner  = (bus.req0 & bus.req1) ? ~r_last : bus.req1;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE: if (bus.req0 | bus.req1) begin
        w_next   = LOAD;
        w_accept = 1'b1;
      end
      LOAD: if (w_clk_enb) w_next = SEND;
      SEND: if (w_clk_enb && bus.xmt_empty) w_next = GAP;
      GAP:  if (w_clk_enb) begin
        w_next   = IDLE;
        w_finish = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_div     <= 4'd0;
      r_last    <= 1'b1;
      r_data    <= 8'd0;
      r_fcnt    <= 8'd0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      r_state <= w_next;
      r_div   <= r_div + 4'd1;
      r_gnt0  <= w_accept & ~w_winner;
      r_gnt1  <= w_accept & w_winner;
      r_done  <= w_finish;
      if (w_accept) begin
        r_last <= w_winner;
        r_data <= w_winner ? bus.data1 : bus.data0;
      end
      // r_last still names the owner of the frame being completed.
      if (w_finish) begin
        r_done_id <= r_last;
        r_fcnt    <= r_fcnt + 8'd1;
      end
    end
  end

  assign bus.shift_ld  = (r_state != LOAD);
  assign bus.clk_enb   = w_clk_enb;
  assign bus.data_out  = r_data;
  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.done      = r_done;
  assign bus.done_id   = r_done_id;
  assign bus.busy      = (r_state != IDLE);
  assign bus.frame_cnt = r_fcnt;
endmodule
